// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the parametrised VGA frame-buffer display path.
// VGA_FB_TESTPAT_EN adds the colour-bar fields to the pipeline record.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_t;

    typedef logic [11:0] rgb444_t;

    // Classic bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb444_t BAR_RGB [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Per-pixel record travelling alongside the BRAM read.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       win;
        logic       fs;
`ifdef VGA_FB_TESTPAT_EN
        logic       tp;
        logic [2:0] bar;
`endif
    } pipe_t;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic region_t region_of(input int cnt, input int active, input int fp, input int sync);
        if (cnt < active)
            return REG_ACTIVE;
        else if (cnt < active + fp)
            return REG_FP;
        else if (cnt < active + fp + sync)
            return REG_SYNC;
        else
            return REG_BP;
    endfunction

endpackage

// File: rtl/vga_fb_display_timing.sv
// VGA raster counters with region decode; sync and de are combinational from
// the registered counters so the top can align them with its own pipeline.
module vga_timing_gen
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HCW      = 10,
    parameter int VCW      = 10
) (
    input  logic           clk,
    input  logic           rst,
    output logic [HCW-1:0] h_cnt_o,
    output logic [VCW-1:0] v_cnt_o,
    output logic           de_o,
    output logic           hs_o,
    output logic           vs_o,
    output logic           line_end_o,
    output logic           frame_end_o
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [HCW-1:0] h_cnt_q, h_cnt_d;
    logic [VCW-1:0] v_cnt_q, v_cnt_d;
    logic           line_end, frame_end;
    region_t        h_region, v_region;

    always_comb begin
        line_end  = (h_cnt_q == HCW'(H_TOTAL - 1));
        frame_end = line_end && (v_cnt_q == VCW'(V_TOTAL - 1));
        h_cnt_d   = line_end ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        if (frame_end)
            v_cnt_d = '0;
        else if (line_end)
            v_cnt_d = v_cnt_q + 1'b1;
        h_region = region_of(int'(h_cnt_q), H_ACTIVE, H_FP, H_SYNC);
        v_region = region_of(int'(v_cnt_q), V_ACTIVE, V_FP, V_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign de_o        = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
    assign hs_o        = (h_region == REG_SYNC);
    assign vs_o        = (v_region == REG_SYNC);
    assign line_end_o  = line_end;
    assign frame_end_o = frame_end;

endmodule

// File: rtl/vga_fb_display.sv
// VGA display from a frame-buffer BRAM: scaled, placeable image window over a border.
// Define VGA_FB_TESTPAT_EN to add the test_mode colour-bar generator.
module vga_fb_display
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int SCALE_LOG2 = 1,
    parameter int X_OFF      = 0,
    parameter int Y_OFF      = 0,
    parameter int RAM_LAT    = 1,
    parameter int ADDR_W     = 17,
    parameter int PIX_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
`ifdef VGA_FB_TESTPAT_EN
    input  logic              test_mode,
`endif
    input  logic [PIX_W-1:0]  border_rgb,
    input  logic [PIX_W-1:0]  ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [PIX_W-1:0]  vga_rgb,
    output logic              frame_start
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int REP     = 1 << SCALE_LOG2;
    localparam int X_END   = X_OFF + (IMG_W << SCALE_LOG2);
    localparam int Y_END   = Y_OFF + (IMG_H << SCALE_LOG2);
    localparam int DLY     = RAM_LAT + 1;

    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_chk_size
        $fatal(1, "vga_fb_display: IMG_W*IMG_H does not fit in ADDR_W");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_chk_scale
        $fatal(1, "vga_fb_display: SCALE_LOG2 must be 0..2");
    end
    if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_chk_lat
        $fatal(1, "vga_fb_display: RAM_LAT must be 1..3");
    end

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           de, hs_act, vs_act, line_end, frame_end;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HCW(HCW), .VCW(VCW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .de_o        (de),
        .hs_o        (hs_act),
        .vs_o        (vs_act),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    int   h_pos, v_pos;
    logic h_in, v_in, win, fetch;

    always_comb begin
        h_pos = int'(h_cnt);
        v_pos = int'(v_cnt);
        h_in  = (h_pos >= X_OFF) && (h_pos < X_END);
        v_in  = (v_pos >= Y_OFF) && (v_pos < Y_END);
        win   = de && h_in && v_in;
`ifdef VGA_FB_TESTPAT_EN
        fetch = win && !test_mode;
`else
        fetch = win;
`endif
    end

    // Incremental addressing: col steps every REP window pixels, row_base every REP window lines.
    logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [1:0]        hrep_q, hrep_d, vrep_q, vrep_d;
    logic              ram_en_q, ram_en_d;

    always_comb begin
        col_d      = col_q;
        hrep_d     = hrep_q;
        row_base_d = row_base_q;
        vrep_d     = vrep_q;
        if (line_end) begin
            col_d  = '0;
            hrep_d = '0;
        end else if (win) begin
            if (hrep_q == 2'(REP - 1)) begin
                hrep_d = '0;
                col_d  = col_q + 1'b1;
            end else begin
                hrep_d = hrep_q + 1'b1;
            end
        end
        if (frame_end) begin
            row_base_d = '0;
            vrep_d     = '0;
        end else if (line_end && v_in) begin
            if (vrep_q == 2'(REP - 1)) begin
                vrep_d     = '0;
                row_base_d = row_base_q + ADDR_W'(IMG_W);
            end else begin
                vrep_d = vrep_q + 1'b1;
            end
        end
        ram_addr_d = fetch ? (row_base_q + col_q) : ram_addr_q;
        ram_en_d   = fetch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            hrep_q     <= '0;
            row_base_q <= '0;
            vrep_q     <= '0;
            ram_addr_q <= '0;
            ram_en_q   <= 1'b0;
        end else begin
            col_q      <= col_d;
            hrep_q     <= hrep_d;
            row_base_q <= row_base_d;
            vrep_q     <= vrep_d;
            ram_addr_q <= ram_addr_d;
            ram_en_q   <= ram_en_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_en   = ram_en_q;

`ifdef VGA_FB_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BPW   = $clog2(BAR_W + 1);

    logic [BPW-1:0] bar_px_q, bar_px_d;
    logic [2:0]     bar_q, bar_d;

    always_comb begin
        bar_px_d = bar_px_q;
        bar_d    = bar_q;
        if (line_end) begin
            bar_px_d = '0;
            bar_d    = '0;
        end else if (de) begin
            if (bar_px_q == BPW'(BAR_W - 1)) begin
                bar_px_d = '0;
                bar_d    = bar_q + 1'b1;
            end else begin
                bar_px_d = bar_px_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_px_q <= '0;
            bar_q    <= '0;
        end else begin
            bar_px_q <= bar_px_d;
            bar_q    <= bar_d;
        end
    end
`endif

    // Delay line matches the address register plus the BRAM latency.
    pipe_t pipe_in;
    pipe_t pipe_q [DLY];

    always_comb begin
        pipe_in     = '0;
        pipe_in.hs  = hs_act;
        pipe_in.vs  = vs_act;
        pipe_in.de  = de;
        pipe_in.win = win;
        pipe_in.fs  = de && (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_FB_TESTPAT_EN
        pipe_in.tp  = test_mode;
        pipe_in.bar = bar_q;
`endif
    end

    for (genvar gi = 0; gi < DLY; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst)
                    pipe_q[gi] <= '0;
                else
                    pipe_q[gi] <= pipe_in;
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (rst)
                    pipe_q[gi] <= '0;
                else
                    pipe_q[gi] <= pipe_q[gi-1];
            end
        end
    end

    pipe_t             tail;
    logic [PIX_W-1:0]  rgb_q, rgb_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, fs_q;

    always_comb begin
        tail  = pipe_q[DLY-1];
        rgb_d = '0;
        if (tail.de) begin
            if (tail.win) begin
                rgb_d = ram_data;
`ifdef VGA_FB_TESTPAT_EN
                if (tail.tp)
                    rgb_d = PIX_W'(BAR_RGB[tail.bar]);
`endif
            end else begin
                rgb_d = border_rgb;
            end
        end
        hs_d = tail.hs ? SYNC_POL : ~SYNC_POL;
        vs_d = tail.vs ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= tail.de;
            fs_q  <= tail.fs;
        end
    end

    assign vga_rgb     = rgb_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign frame_start = fs_q;

endmodule
